// File: rtl/muldiv_unit.sv
// 32-bit iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 33 cycles per operation.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  op_q;
    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic [5:0]  cnt;

    logic        accept;
    logic        in_signed;
    logic        in_sa;
    logic        in_sb;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        is_div;
    logic        is_signed;

    assign accept    = (state == IDLE) && start && !flush;
    assign in_signed = ~op[0];
    assign in_sa     = in_signed & a[31];
    assign in_sb     = in_signed & b[31];
    assign abs_a     = in_sa ? -a : a;
    assign abs_b     = in_sb ? -b : b;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign busy      = (state != IDLE);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [32:0] mul_sum;
    logic [63:0] mul_nx;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [63:0] div_nx;

    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mag_b : 32'd0};
    assign mul_nx   = {mul_sum, acc[31:1]};
    assign div_sh   = {acc[63:32], acc[31]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_nx   = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod   = (is_signed && (sa ^ sb)) ? -acc : acc;
        quo    = (is_signed && (sa ^ sb)) ? -acc[31:0] : acc[31:0];
        rem    = (is_signed && sa) ? -acc[63:32] : acc[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = quo;
            // Divide by zero returns the raw dividend, rebuilt from |a|
            if (mag_b == 32'd0) begin
                res_hi = sa ? -mag_a : mag_a;
                res_lo = 32'hFFFF_FFFF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                if (flush)               state_nx = IDLE;
                else if (cnt == 6'd31)   state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= 2'b00;
            sa    <= 1'b0;
            sb    <= 1'b0;
            mag_a <= 32'd0;
            mag_b <= 32'd0;
            acc   <= 64'd0;
            cnt   <= 6'd0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (accept) begin
                        op_q  <= op;
                        sa    <= in_sa;
                        sb    <= in_sb;
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        acc   <= {32'd0, abs_a};
                        cnt   <= 6'd0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= is_div ? div_nx : mul_nx;
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass;
    int n_total;
    bit done_in_busy;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .a(a), .b(b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (busy && done) done_in_busy = 1'b1;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] rh,
                                   output logic [31:0] rl);
        longint sx, sy;
        longint unsigned ux, uy;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = 64'd0;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = ux * uy;
            2'b10: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
            default: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    // Call between a negedge and the next posedge; returns at the negedge after accept.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic finish(output int lat);
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int lat;
        launch(o, x, y);
        finish(lat);
        check({name, " latency"}, lat, 33);
        check({name, " done"}, done, 1);
        check({name, " hi/lo"}, {hi, lo}, {eh, el});
        @(negedge clk);
        check({name, " done pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int lat;
        logic [31:0] eh, el;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{"mult -3*5",   2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{"divu 7/0",    2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
        vecs[5] = '{"div -7/0",    2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{"div 7/-2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{"mult min*min",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        n_pass = 0;
        n_total = 0;
        done_in_busy = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = 32'd0;
        b = 32'd0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd = 32'd0;
        repeat (2) @(negedge clk);
        check("reset state", {busy, done, hi, lo}, 66'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                                 vecs[i].hi, vecs[i].lo);

        // A start and MT writes during busy must be dropped
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        finish(lat);
        check("ignored start latency", lat + 5, 33);
        check("ignored start result", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        @(negedge clk);
        check("no queued op", {busy, done}, 2'b00);

        // MTHI together with start: written now, result overwrites later
        hi_we = 1'b1; wd = 32'hCAFE_0001;
        launch(2'b01, 32'd3, 32'd4);
        hi_we = 1'b0;
        check("mthi with start", hi, 32'hCAFE_0001);
        finish(lat);
        check("mthi then result", {hi, lo}, {32'd0, 32'd12});

        // Flush during CALC
        lo_we = 1'b1; wd = 32'h1234_5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", lo, 32'h1234_5678);
        launch(2'b11, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush calc", {busy, done, lo}, {2'b00, 32'h1234_5678});
        @(negedge clk);
        check("flush no done", done, 0);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        // Flush in FIX wins over completion
        launch(2'b00, 32'd6, 32'd7);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush fix", {busy, done, hi, lo}, {2'b00, 32'd2, 32'd14});

        // Flush in IDLE blocks a coincident start
        flush = 1'b1;
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush blocks start", {busy, hi, lo}, {1'b0, 32'd2, 32'd14});

        // Asynchronous reset mid-CALC
        launch(2'b10, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("async reset", {busy, done, hi, lo}, 66'd0);
        reset_n = 1'b1;
        run_op("start after reset", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 9);
                2: rb = -$urandom_range(1, 9);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_op(ro, ra, rb, eh, el);
            run_op($sformatf("random %0d", i), ro, ra, rb, eh, el);
        end

        check("done never with busy", done_in_busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
